// File: rtl/sound_loc_pkg.sv
// sound_loc_pkg: shared sample widths and the FIFO entry layout.
package sound_loc_pkg;
  localparam int SAMPLE_W = 16;
  localparam int CH_W = 3;
  typedef struct packed {
    logic [CH_W-1:0]     ch;
    logic [SAMPLE_W-1:0] data;
  } entry_t;
endpackage

// File: rtl/sample_framer_if.sv
// sample_framer_if: sample input stream and tagged output stream of the framer.
interface sample_framer_if;
  import sound_loc_pkg::*;
  logic [SAMPLE_W-1:0] in_data;
  logic                in_valid;
  logic [SAMPLE_W-1:0] out_data;
  logic [CH_W-1:0]     out_ch;
  logic                out_sof;
  logic                out_valid;
  logic                out_ready;
  modport slave (input in_data, in_valid, out_ready, output out_data, out_ch, out_sof, out_valid);
  modport master (output in_data, in_valid, out_ready, input out_data, out_ch, out_sof, out_valid);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: circular FIFO with extra-MSB pointers; head is read straight from storage.
module sync_fifo #(
  parameter int W = 19,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   free
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic full, empty;
  assign empty = wptr == rptr;
  assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign valid = !empty;
  // Head reads as zero when empty so outputs are clean after reset.
  assign rdata = empty ? '0 : mem[rptr[AW-1:0]];
  assign free = (AW+1)'(DEPTH) - (wptr - rptr);
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (push && !full) mem[wptr[AW-1:0]] <= wdata;
endmodule

// File: rtl/sample_framer.sv
// sample_framer: tags ADC samples with channel index, admits whole frames into a FIFO,
// drops frames that do not fit and truncates frames after an input gap.
module sample_framer
  import sound_loc_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DEPTH = 16,
  parameter int GAP_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  sample_framer_if.slave       bus,
  input  logic                 clr_flags,
  output logic                 overflow,
  output logic                 partial,
  output logic [15:0]          frame_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [CH_W-1:0] LAST = CH_W'(NUM_CH - 1);
  localparam logic [GW-1:0] GAP = GW'(GAP_CYCLES);
  logic [CH_W-1:0] ch_idx;
  logic [GW-1:0] gap;
  logic drop, fits, last, push, drop_set, timeout, valid;
  logic [AW:0] free;
  entry_t wr, rd;
  assign fits = free >= (AW+1)'(NUM_CH);
  assign last = ch_idx == LAST;
  assign push = bus.in_valid && (ch_idx == '0 ? fits : !drop);
  assign drop_set = bus.in_valid && ch_idx == '0 && !fits;
  // Timeout fires on the edge where the timer steps onto GAP_CYCLES.
  assign timeout = !bus.in_valid && gap == GAP - 1'b1 && ch_idx != '0;
  assign wr = '{ch: ch_idx, data: bus.in_data};
  sync_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .wdata(wr),
    .pop(bus.out_ready),
    .rdata(rd),
    .valid(valid),
    .free(free)
  );
  assign bus.out_data = rd.data;
  assign bus.out_ch = rd.ch;
  assign bus.out_valid = valid;
  assign bus.out_sof = valid && rd.ch == '0;
  always_ff @(posedge clk) begin
    if (!rst) begin
      ch_idx <= '0;
      gap <= '0;
      drop <= 1'b0;
      overflow <= 1'b0;
      partial <= 1'b0;
      frame_count <= '0;
    end else begin
      gap <= bus.in_valid ? '0 : (gap == GAP ? gap : gap + 1'b1);
      if (bus.in_valid) begin
        ch_idx <= last ? '0 : ch_idx + 1'b1;
        drop <= last ? 1'b0 : (ch_idx == '0 ? !fits : drop);
      end else if (timeout) begin
        ch_idx <= '0;
        drop <= 1'b0;
      end
      overflow <= drop_set || (overflow && !clr_flags);
      partial <= (timeout && !drop) || (partial && !clr_flags);
      if (push && last) frame_count <= frame_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_sample_framer.sv
// tb_sample_framer: directed checks of tagging, admission, timeout, FIFO order and reset.
module tb_sample_framer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr_flags = 1'b0;
  logic overflow, partial;
  logic [15:0] frame_count;
  int errors = 0;
  int checks = 0;
  sample_framer_if bus();
  sample_framer dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .clr_flags(clr_flags),
    .overflow(overflow),
    .partial(partial),
    .frame_count(frame_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic head(input string tag, input logic [15:0] d, input logic [2:0] c);
    chk({tag, " valid"}, 32'(bus.out_valid), 1);
    chk({tag, " data"}, 32'(bus.out_data), 32'(d));
    chk({tag, " ch"}, 32'(bus.out_ch), 32'(c));
    chk({tag, " sof"}, 32'(bus.out_sof), 32'(c == 3'd0));
  endtask
  task automatic send(input logic [15:0] d);
    bus.in_data = d;
    bus.in_valid = 1'b1;
    @(negedge clk);
  endtask
  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask
  initial begin
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst out_valid", 32'(bus.out_valid), 0);
    chk("rst out_data", 32'(bus.out_data), 0);
    chk("rst out_ch", 32'(bus.out_ch), 0);
    chk("rst out_sof", 32'(bus.out_sof), 0);
    chk("rst frame_count", 32'(frame_count), 0);
    chk("rst overflow", 32'(overflow), 0);
    chk("rst partial", 32'(partial), 0);
    rst = 1'b1;
    // Three back-to-back frames with the consumer always ready.
    bus.out_ready = 1'b1;
    for (int f = 0; f < 3; f++)
      for (int c = 0; c < 4; c++) begin
        send(16'((f + 1) * 256 + c));
        head("stream", 16'((f + 1) * 256 + c), 3'(c));
      end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("stream frame_count", 32'(frame_count), 3);
    chk("stream drained", 32'(bus.out_valid), 0);
    // Five frames into a stalled FIFO; clr_flags collides with the drop.
    do_reset();
    bus.out_ready = 1'b0;
    for (int f = 0; f < 5; f++)
      for (int c = 0; c < 4; c++) begin
        clr_flags = (f == 4 && c == 0);
        send(16'((f + 1) * 256 + c));
      end
    clr_flags = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("ovf overflow", 32'(overflow), 1);
    chk("ovf frame_count", 32'(frame_count), 4);
    chk("ovf partial", 32'(partial), 0);
    head("ovf hold", 16'h0100, 3'd0);
    @(negedge clk);
    head("ovf hold2", 16'h0100, 3'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      head("ovf drain", 16'((i / 4 + 1) * 256 + i % 4), 3'(i % 4));
      @(negedge clk);
    end
    chk("ovf drained", 32'(bus.out_valid), 0);
    chk("ovf still set", 32'(overflow), 1);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    chk("ovf cleared", 32'(overflow), 0);
    // Twelve stored, then ten cycles of simultaneous push and pop.
    do_reset();
    bus.out_ready = 1'b0;
    for (int j = 0; j < 12; j++) send(16'hA000 + 16'(j));
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.in_data = 16'hA000 + 16'(12 + k);
      bus.in_valid = 1'b1;
      head("pushpop", 16'hA000 + 16'(k), 3'(k % 4));
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    for (int k = 10; k < 22; k++) begin
      head("pushpop drain", 16'hA000 + 16'(k), 3'(k % 4));
      @(negedge clk);
    end
    chk("pushpop drained", 32'(bus.out_valid), 0);
    chk("pushpop frame_count", 32'(frame_count), 5);
    // Two samples, a 64-cycle gap, then a full frame.
    do_reset();
    bus.out_ready = 1'b1;
    send(16'h5000);
    head("gap s0", 16'h5000, 3'd0);
    send(16'h5001);
    head("gap s1", 16'h5001, 3'd1);
    bus.in_valid = 1'b0;
    repeat (63) @(negedge clk);
    chk("gap partial at 63", 32'(partial), 0);
    @(negedge clk);
    chk("gap partial at 64", 32'(partial), 1);
    for (int c = 0; c < 4; c++) begin
      send(16'h5100 + 16'(c));
      head("gap frame", 16'h5100 + 16'(c), 3'(c));
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("gap frame_count", 32'(frame_count), 1);
    // Reset mid-frame with seven entries stored.
    bus.out_ready = 1'b0;
    for (int j = 0; j < 7; j++) send(16'h7000 + 16'(j));
    bus.in_valid = 1'b0;
    head("mid stored", 16'h7000, 3'd0);
    chk("mid frame_count", 32'(frame_count), 2);
    rst = 1'b0;
    @(negedge clk);
    chk("mid rst out_valid", 32'(bus.out_valid), 0);
    chk("mid rst frame_count", 32'(frame_count), 0);
    chk("mid rst overflow", 32'(overflow), 0);
    chk("mid rst partial", 32'(partial), 0);
    rst = 1'b1;
    send(16'h7777);
    bus.in_valid = 1'b0;
    head("mid first", 16'h7777, 3'd0);
    @(negedge clk);
    head("mid first hold", 16'h7777, 3'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sample_framer.md
SAMPLE_FRAMER -- requirements
Module: sample_framer

Interface
REQ-001 Parameter NUM_CH, default 4: ADC samples per frame (conversion group), range 2..8.
REQ-002 Parameter DEPTH, default 16: FIFO entries (samples), power of 2, at least 2*NUM_CH.
REQ-003 Parameter GAP_CYCLES, default 64: idle cycles that end a partial frame.
REQ-004 clk  in  1  clock; all logic on posedge clk.
REQ-005 rst  in  1  reset rst, synchronous, active-low.
REQ-006 in_data  in  16  ADC sample word from the ADC driver's memory port.
REQ-007 in_valid  in  1  sample qualifier; each cycle in_valid=1 delivers exactly one sample.
REQ-008 out_data  out  16  FIFO head sample.
REQ-009 out_ch  out  3  channel index of the head sample, 0..NUM_CH-1.
REQ-010 out_sof  out  1  head sample is channel 0 (start of frame).
REQ-011 out_valid  out  1  head entry valid.
REQ-012 out_ready  in  1  consumer accepts head; pop on out_valid & out_ready.
REQ-013 overflow  out  1  sticky: at least one frame dropped.
REQ-014 partial  out  1  sticky: at least one frame truncated by gap timeout.
REQ-015 clr_flags  in  1  single-cycle clear of overflow and partial.
REQ-016 frame_count  out  16  complete frames written to the FIFO.

Function
REQ-017 ch_idx counter: each accepted sample is tagged ch_idx; ch_idx then increments, wrapping NUM_CH-1 -> 0.
REQ-018 Frame admission: when a sample arrives with ch_idx=0, the frame is admitted only if FIFO free entries >= NUM_CH, evaluated that cycle before any write.
REQ-019 Non-admitted frame: set drop_frame; all NUM_CH samples of the frame are discarded; set overflow; clear drop_frame when ch_idx wraps to 0.
REQ-020 Admitted frames write every sample in the cycle it arrives, so an admitted frame never overflows mid-frame.
REQ-021 frame_count increments, wrapping 0xFFFF -> 0, in the cycle the channel-(NUM_CH-1) sample of an admitted frame is written.
REQ-022 Gap timer: reset to 0 on every in_valid; otherwise increment, saturating at GAP_CYCLES.
REQ-023 Timeout: when the gap timer reaches GAP_CYCLES with ch_idx != 0, ch_idx <= 0, drop_frame <= 0, and partial <= 1 if the frame was admitted; samples already written remain; frame_count is not incremented.
REQ-024 A timeout coinciding with in_valid does not occur, because in_valid resets the timer.
REQ-025 FIFO is circular with (log2 DEPTH)+1-bit read and write pointers; full = MSBs differ and LSBs equal; empty = pointers equal.
REQ-026 Each FIFO entry is 19 bits: {ch[2:0], data[15:0]}; out_sof = (out_ch == 0).
REQ-027 Latency: a sample written into an empty FIFO appears with out_valid=1 on the next cycle; the FIFO does not fall through combinationally.
REQ-028 A push and a pop in the same cycle are both performed and occupancy is unchanged; a pop when empty is ignored.
REQ-029 out_data, out_ch and out_valid stay stable while out_valid=1 and out_ready=0.
REQ-030 clr_flags coinciding with a new drop or timeout: the set wins and the flag reads 1 next cycle.

Reset
REQ-031 While rst=0 at a clk edge, all of these reset to 0: pointers, ch_idx, gap timer, drop_frame, overflow, partial, frame_count, out_valid, out_data, out_ch, out_sof.
REQ-032 Reset mid-frame or with a non-empty FIFO discards all contents; the first sample after reset is channel 0.

Structure
REQ-033 Shared package sound_loc_pkg holds: SAMPLE_W=16, CH_W=3, and the fifo entry struct {ch, data}.
REQ-034 Storage is one sub-module, sync_fifo, parameterised by width and DEPTH; the framer holds the admission, timer and tagging logic.

Verification
REQ-035 Defaults, out_ready=1, 3 frames of samples 0x0100..0x0103 etc. on consecutive cycles -> outputs in order with ch 0,1,2,3, out_sof on ch0, frame_count=3.
REQ-036 out_ready=0, 5 frames (20 samples) -> frames 1-4 stored, frame 5 fully dropped, overflow=1, frame_count=4; drain -> 16 samples, then out_valid=0.
REQ-037 2 samples, then 64 idle cycles, then 4 samples -> partial=1, new frame tagged ch0..3, frame_count=1.
REQ-038 FIFO with 12 entries, push and pop in the same cycle for 10 cycles -> occupancy stays 12, data order preserved.
REQ-039 rst=0 asserted mid-frame with 7 entries stored -> next cycle out_valid=0, frame_count=0, flags 0; next sample tagged ch0.
REQ-040 clr_flags pulsed in the same cycle as a frame drop -> overflow=1; clr_flags pulsed alone afterwards -> overflow=0.
